// File: rtl/pc_stack_unit_if.sv
// Bundle between instruction decode and the program counter / return-address stack.
// The master (decode) drives the op and its operands; the slave (PC unit) returns PC and stack status.
interface pc_stack_unit_if #(
  parameter int AW    = 8,
  parameter int RW    = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          en_pc;
  logic [2:0]    op_pc;
  logic [AW-1:0] pc_iaddr;
  logic [RW-1:0] pc_rel;
  logic          clr_flags;
  logic [AW-1:0] pc_oaddr;
  logic [CW-1:0] stk_cnt;
  logic          stk_ovf;
  logic          stk_unf;

  modport master (
    output en_pc, op_pc, pc_iaddr, pc_rel, clr_flags,
    input  pc_oaddr, stk_cnt, stk_ovf, stk_unf
  );

  modport slave (
    input  en_pc, op_pc, pc_iaddr, pc_rel, clr_flags,
    output pc_oaddr, stk_cnt, stk_ovf, stk_unf
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with return-address stack, signed relative branches, skip and stall.
// The new PC is registered and appears one cycle after the op is sampled.
module pc_stack_unit #(
  parameter int            AW        = 8,
  parameter int            RW        = 8,
  parameter int            DEPTH     = 4,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic            clk_pc,
  input  logic            rst_pc,
  pc_stack_unit_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NEXT  = 3'd0,
    OP_SKIP  = 3'd1,
    OP_JMP   = 3'd2,
    OP_RJMP  = 3'd3,
    OP_CALL  = 3'd4,
    OP_RCALL = 3'd5,
    OP_RET   = 3'd6,
    OP_HOLD  = 3'd7
  } op_e;

  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] stk_q [DEPTH];

  logic [AW-1:0] rel_sx;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_skip;
  logic [AW-1:0] pc_rtgt;
  logic          stk_full;
  logic          stk_empty;
  logic          push;
  logic          push_wr;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] pop_idx;
  op_e           op;

  // Sign-extend the relative offset bit by bit so RW == AW needs no zero-width replication.
  for (genvar i = 0; i < AW; i++) begin : g_sx
    if (i < RW) begin : g_lo
      assign rel_sx[i] = bus.pc_rel[i];
    end else begin : g_hi
      assign rel_sx[i] = bus.pc_rel[RW-1];
    end
  end

  assign op        = op_e'(bus.op_pc);
  assign pc_inc    = pc_q + AW'(1);
  assign pc_skip   = pc_q + AW'(2);
  assign pc_rtgt   = pc_inc + rel_sx;
  assign stk_full  = (cnt_q == CW'(DEPTH));
  assign stk_empty = (cnt_q == '0);
  assign push_idx  = IW'(cnt_q);
  assign pop_idx   = IW'(cnt_q - CW'(1));
  assign push_wr   = bus.en_pc && push && !stk_full;

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (bus.en_pc) begin
      if (bus.clr_flags) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      case (op)
        OP_NEXT:  pc_d = pc_inc;
        OP_SKIP:  pc_d = pc_skip;
        OP_JMP:   pc_d = bus.pc_iaddr;
        OP_RJMP:  pc_d = pc_rtgt;
        OP_CALL: begin
          pc_d = bus.pc_iaddr;
          push = 1'b1;
        end
        OP_RCALL: begin
          pc_d = pc_rtgt;
          push = 1'b1;
        end
        OP_RET: begin
          if (stk_empty) begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end else begin
            pc_d  = stk_q[pop_idx];
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: pc_d = pc_q;
      endcase
      // A full stack still takes the jump; only the return address is lost.
      if (push) begin
        if (stk_full) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_pc or negedge rst_pc) begin
    if (!rst_pc) begin
      pc_q  <= RESET_VEC;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk_pc) begin
    if (push_wr) begin
      stk_q[push_idx] <= pc_inc;
    end
  end

  assign bus.pc_oaddr = pc_q;
  assign bus.stk_cnt  = cnt_q;
  assign bus.stk_ovf  = ovf_q;
  assign bus.stk_unf  = unf_q;
endmodule
